// File: rtl/addsub_ser.sv
// Digit-serial adder/subtractor. Operands are latched on start and
// processed DIGIT bits per clock, least significant digit first. The
// result, carry-out and signed overflow are held until the next start.
module addsub_ser #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned DigW = DIGIT + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;   // holds B' (b inverted in subtract mode)
    logic [WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic [DigW-1:0]  dig_sum;
    logic             last_dig;

    // Next-state logic: operand load on start, one digit per cycle in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;

        // Operand registers shift right, so the current digit is always the low one
        dig_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DigW'(carry_q);
        last_dig = (cnt_q == CntW'(NDIG - 1));

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = ci ^ sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // New digit enters at the top; after NDIG shifts digit i sits at i*DIGIT
                s_d     = (s_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = dig_sum[DIGIT];
                cnt_d   = cnt_q + CntW'(1);
                if (last_dig) begin
                    // Low digit of the shifted operands now holds the original sign bits
                    co_d    = dig_sum[DIGIT];
                    ov_d    = (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                              (dig_sum[DIGIT-1] != a_q[DIGIT-1]);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_addsub_ser.sv
// Directed and random checks of the digit-serial adder/subtractor, with a
// 16-bit/4-bit-digit instance and an 8-bit single-digit instance.
module tb_addsub_ser;

    logic clk = 1'b0;
    logic rst;

    logic        start16, sub16, ci16, busy16, done16, co16, ov16;
    logic [15:0] a16, b16, s16;
    logic        start8, sub8, ci8, busy8, done8, co8, ov8;
    logic [7:0]  a8, b8, s8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    addsub_ser #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .ci(ci16),
        .busy(busy16), .done(done16), .s(s16), .co(co16), .ov(ov16)
    );

    addsub_ser #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic cv);
        if (w8) begin
            a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; ci8 = cv; start8 = 1'b1;
        end else begin
            a16 = av; b16 = bv; sub16 = sv; ci16 = cv; start16 = 1'b1;
        end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Counts busy cycles until the DUT leaves RUN, bounded
    task automatic finish_op(input bit w8, output int nb);
        nb = 0;
        while ((w8 ? busy8 : busy16) && nb < 20) begin
            nb++;
            tick();
        end
    endtask

    task automatic expect_result(input string tag, input bit w8, input int nb, input int nb_exp,
                                 input logic [15:0] se, input logic ce, input logic oe);
        check({tag, ".busy_cycles"}, nb, nb_exp);
        check({tag, ".done"}, w8 ? done8 : done16, 1);
        check({tag, ".s"}, w8 ? {8'h0, s8} : s16, se);
        check({tag, ".co"}, w8 ? co8 : co16, ce);
        check({tag, ".ov"}, w8 ? ov8 : ov16, oe);
    endtask

    task automatic run_op(input string tag, input bit w8, input logic [15:0] av,
                          input logic [15:0] bv, input logic sv, input logic cv,
                          input logic [15:0] se, input logic ce, input logic oe);
        int nb;
        launch(w8, av, bv, sv, cv);
        finish_op(w8, nb);
        expect_result(tag, w8, nb, w8 ? 1 : 4, se, ce, oe);
    endtask

    // Independent arithmetic reference for the random sweep
    task automatic model(input bit w8, input int unsigned av, input int unsigned bv,
                         input bit sv, input bit cv,
                         output logic [15:0] se, output logic ce, output logic oe);
        int unsigned mask, msb, aa, bb, r;
        bit sa, sb, ss;
        mask = w8 ? 32'hFF : 32'hFFFF;
        msb  = w8 ? 7 : 15;
        aa = av & mask;
        bb = bv & mask;
        if (!sv) begin
            r  = aa + bb + cv;
            ce = ((r >> (msb + 1)) & 1) != 0;
        end else begin
            r  = aa - bb - cv;
            ce = aa >= bb + cv;
        end
        r  = r & mask;
        se = r[15:0];
        sa = ((aa >> msb) & 1) != 0;
        sb = ((bb >> msb) & 1) != 0;
        ss = ((r >> msb) & 1) != 0;
        oe = sv ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb;
        bit saw_done;
        logic [15:0] se;
        logic ce, oe;
        int unsigned ra, rb;
        bit rs, rc;

        rst = 1'b1;
        start16 = 0; sub16 = 0; ci16 = 0; a16 = '0; b16 = '0;
        start8 = 0; sub8 = 0; ci8 = 0; a8 = '0; b8 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.busy16", busy16, 0);
        check("reset.done16", done16, 0);
        check("reset.s16", s16, 0);
        check("reset.co_ov16", {co16, ov16}, 0);
        check("reset.s8", {busy8, done8, co8, ov8, s8}, 0);

        // Directed vectors
        run_op("add_00ff_0001", 0, 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        tick();
        check("add_00ff.done_pulse", done16, 0);
        check("add_00ff.s_held", s16, 16'h0100);
        run_op("add_ffff_0001", 0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        run_op("add_7fff_ci", 0, 16'h7FFF, 16'h0000, 0, 1, 16'h8000, 0, 1);
        run_op("sub_5_7", 0, 16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
        run_op("sub_8000_1", 0, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1);

        // start during RUN ignored; operand inputs changing mid-operation ignored
        launch(0, 16'h1234, 16'h1111, 0, 0);
        tick();
        a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; ci16 = 1'b1; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        finish_op(0, nb);
        expect_result("ignore_start", 0, nb, 2, 16'h2345, 0, 0);

        // start in the DONE cycle is accepted back-to-back
        launch(0, 16'h0F0F, 16'h0101, 1, 1);
        check("b2b.busy_next", busy16, 1);
        check("b2b.done_next", done16, 0);
        finish_op(0, nb);
        expect_result("b2b", 0, nb, 4, 16'h0E0D, 1, 0);

        // Reset on the third RUN cycle aborts with no done pulse
        launch(0, 16'hAAAA, 16'h5555, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort.busy", busy16, 0);
        check("rst_abort.s", s16, 0);
        check("rst_abort.co_ov", {co16, ov16}, 0);
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done16) saw_done = 1;
            tick();
        end
        check("rst_abort.no_done", saw_done, 0);
        run_op("after_rst", 0, 16'h1234, 16'h4321, 0, 1, 16'h5556, 0, 0);

        // Single-digit instance
        run_op("w8_add_80_80", 1, 16'h0080, 16'h0080, 0, 0, 16'h0000, 1, 1);
        run_op("w8_sub_00_01", 1, 16'h0000, 16'h0001, 1, 0, 16'h00FF, 0, 0);

        // Random sweep, both modes, both instances
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = (i % 2) != 0;
            rc = ($urandom_range(0, 1) != 0);
            model(i >= 12, ra, rb, rs, rc, se, ce, oe);
            run_op($sformatf("rand%0d", i), i >= 12, ra[15:0], rb[15:0], rs, rc, se, ce, oe);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
